// File: rtl/tank_timing_pkg.sv
// Shared circulation-timing constants and types for the delay-line store.
// Used by the access sequencer and by the arithmetic unit timing.
package tank_timing_pkg;

    localparam int unsigned WORD_BITS  = 18;
    localparam int unsigned TANK_WORDS = 32;
    localparam int unsigned TANK_BITS  = 5;
    localparam int unsigned POS_BITS   = $clog2(TANK_WORDS);
    localparam int unsigned ADDR_BITS  = TANK_BITS + POS_BITS;
    localparam int unsigned DIGIT_BITS = $clog2(WORD_BITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SLOT,
        ST_XFER,
        ST_ACK
    } seq_state_t;

    typedef struct packed {
        logic [TANK_BITS-1:0] tank;
        logic [POS_BITS-1:0]  pos;
    } tank_addr_t;

endpackage

// File: rtl/tank_timing_counter.sv
// Free-running digit / minor-cycle counter modelling tank circulation.
// Never stalls; shared with the arithmetic unit so both see one phase.
module tank_timing_counter #(
    parameter int unsigned WORD_BITS  = tank_timing_pkg::WORD_BITS,
    parameter int unsigned TANK_WORDS = tank_timing_pkg::TANK_WORDS
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [$clog2(WORD_BITS)-1:0]  digit,
    output logic [$clog2(TANK_WORDS)-1:0] minor,
    output logic                          digit_last_c
);

    localparam int unsigned DIGIT_W = $clog2(WORD_BITS);
    localparam int unsigned MINOR_W = $clog2(TANK_WORDS);

    assign digit_last_c = (digit == DIGIT_W'(WORD_BITS - 1));

    // Minor wraps by natural overflow since TANK_WORDS is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= '0;
            minor <= '0;
        end else if (digit_last_c) begin
            digit <= '0;
            minor <= minor + MINOR_W'(1);
        end else begin
            digit <= digit + DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/tank_access_sequencer.sv
// Serial access sequencer for the mercury-delay-line store: waits for the
// addressed word to circulate round, then opens the tank gate for one word time.
module tank_access_sequencer #(
    parameter int unsigned WORD_BITS  = tank_timing_pkg::WORD_BITS,
    parameter int unsigned TANK_WORDS = tank_timing_pkg::TANK_WORDS,
    parameter int unsigned TANK_BITS  = tank_timing_pkg::TANK_BITS
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    req,
    input  logic                                    req_write,
    input  logic                                    req_long,
    input  logic [TANK_BITS+$clog2(TANK_WORDS)-1:0] req_addr,
    output logic                                    ack,
    output logic                                    busy,
    output logic                                    t_in,
    output logic                                    t_out,
    output logic [TANK_BITS-1:0]                    tank_num,
    output logic [$clog2(WORD_BITS)-1:0]            digit,
    output logic [$clog2(TANK_WORDS)-1:0]           minor,
    output logic                                    second_half
);

    import tank_timing_pkg::*;

    localparam int unsigned POS_W = $clog2(TANK_WORDS);

    tank_addr_t        req_fields;
    seq_state_t        state;
    logic              cap_write;
    logic              cap_long;
    logic [POS_W-1:0]  cap_pos;
    logic              digit_last;
    logic              slot_due;

    tank_timing_counter #(
        .WORD_BITS  (WORD_BITS),
        .TANK_WORDS (TANK_WORDS)
    ) u_counter (
        .clk          (clk),
        .rst          (rst),
        .digit        (digit),
        .minor        (minor),
        .digit_last_c (digit_last)
    );

    assign req_fields = tank_addr_t'(req_addr);

    // Last digit of the minor cycle preceding the target: gate opens next cycle.
    assign slot_due = digit_last && ((minor + POS_W'(1)) == cap_pos);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cap_write   <= 1'b0;
            cap_long    <= 1'b0;
            cap_pos     <= '0;
            tank_num    <= '0;
            ack         <= 1'b0;
            busy        <= 1'b0;
            t_in        <= 1'b0;
            t_out       <= 1'b0;
            second_half <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        cap_write <= req_write;
                        cap_long  <= req_long;
                        // Long words always occupy an even/odd position pair.
                        cap_pos   <= req_long ? {req_fields.pos[POS_W-1:1], 1'b0}
                                              : req_fields.pos;
                        tank_num  <= req_fields.tank;
                        busy      <= 1'b1;
                        state     <= ST_WAIT_SLOT;
                    end
                end
                ST_WAIT_SLOT: begin
                    if (slot_due) begin
                        t_in  <= cap_write;
                        t_out <= !cap_write;
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (digit_last) begin
                        if (cap_long && !second_half) begin
                            second_half <= 1'b1;
                        end else begin
                            second_half <= 1'b0;
                            t_in        <= 1'b0;
                            t_out       <= 1'b0;
                            ack         <= 1'b1;
                            state       <= ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tank_access_sequencer.sv
// Directed bench for tank_access_sequencer: short, wrap-around, long,
// changes while busy, reset mid-transfer and back-to-back accesses.
module tb_tank_access_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       req_write;
    logic       req_long;
    logic [9:0] req_addr;
    logic       ack;
    logic       busy;
    logic       t_in;
    logic       t_out;
    logic [4:0] tank_num;
    logic [4:0] digit;
    logic [4:0] minor;
    logic       second_half;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    tank_access_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_write   (req_write),
        .req_long    (req_long),
        .req_addr    (req_addr),
        .ack         (ack),
        .busy        (busy),
        .t_in        (t_in),
        .t_out       (t_out),
        .tank_num    (tank_num),
        .digit       (digit),
        .minor       (minor),
        .second_half (second_half)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_ack"},   32'(ack), 0);
        chk({tag, "_t_in"},  32'(t_in), 0);
        chk({tag, "_t_out"}, 32'(t_out), 0);
        chk({tag, "_tank"},  32'(tank_num), 0);
        chk({tag, "_digit"}, 32'(digit), 0);
        chk({tag, "_minor"}, 32'(minor), 0);
        chk({tag, "_sh"},    32'(second_half), 0);
    endtask

    initial begin
        int n;
        int clash;
        int sh_cnt;
        int sh_bad;
        int c0;
        int r0;
        int acks;

        rst = 1'b1; req = 1'b0; req_write = 1'b0; req_long = 1'b0; req_addr = '0;
        tick();
        tick();
        cyc = 0;
        chk_all_zero("reset");
        rst = 1'b0;

        // Short read of tank 1, position 3
        tick();
        chk("c1_digit", 32'(digit), 1);
        req = 1'b1; req_write = 1'b0; req_long = 1'b0; req_addr = 10'h023;
        tick();
        chk("short_busy", 32'(busy), 1);
        clash = 0;
        while (!t_out && cyc < 200) begin
            if (t_in) clash++;
            tick();
        end
        chk("short_rise_cycle", 32'(cyc), 54);
        chk("short_rise_minor", 32'(minor), 3);
        chk("short_rise_digit", 32'(digit), 0);
        chk("short_tank", 32'(tank_num), 1);
        n = 0;
        while (t_out && n < 100) begin
            if (t_in || tank_num != 5'd1) clash++;
            n++;
            tick();
        end
        chk("short_width", 32'(n), 18);
        chk("short_ack_cycle", 32'(cyc), 72);
        chk("short_ack", 32'(ack), 1);
        chk("short_clash", 32'(clash), 0);
        req = 1'b0;
        tick();
        chk("short_ack_drop", 32'(ack), 0);
        chk("short_busy_drop", 32'(busy), 0);

        // Wrap-around write to pos 0 captured at digit 1 of minor 0; request changed while busy
        n = 0;
        while (!(digit == 5'd1 && minor == 5'd0) && n < 700) begin
            n++;
            tick();
        end
        chk("wrap_sync_digit", 32'(digit), 1);
        chk("wrap_sync_minor", 32'(minor), 0);
        c0 = cyc;
        req = 1'b1; req_write = 1'b1; req_long = 1'b0; req_addr = 10'h040;
        tick();
        req_addr = 10'h3FF; req_write = 1'b0; req_long = 1'b1;
        clash = 0;
        while (!t_in && (cyc - c0) < 700) begin
            if (t_out) clash++;
            tick();
        end
        chk("wrap_rise_delay", 32'(cyc - c0), 575);
        chk("wrap_rise_minor", 32'(minor), 0);
        chk("wrap_tank", 32'(tank_num), 2);
        n = 0;
        while (t_in && n < 100) begin
            if (t_out || second_half) clash++;
            n++;
            tick();
        end
        chk("wrap_width", 32'(n), 18);
        chk("wrap_ack", 32'(ack), 1);
        chk("wrap_clash", 32'(clash), 0);
        req = 1'b0;
        tick();

        // Long read of 0x3E5: position forced to 4, spans minors 4 and 5
        c0 = cyc;
        req = 1'b1; req_write = 1'b0; req_long = 1'b1; req_addr = 10'h3E5;
        tick();
        while (!t_out && (cyc - c0) < 700) tick();
        chk("long_rise_delay", 32'(cyc - c0), 53);
        chk("long_rise_minor", 32'(minor), 4);
        chk("long_rise_digit", 32'(digit), 0);
        chk("long_tank", 32'(tank_num), 31);
        n = 0; sh_cnt = 0; sh_bad = 0;
        while (t_out && n < 100) begin
            n++;
            if (second_half) begin
                sh_cnt++;
                if (minor != 5'd5) sh_bad++;
            end else if (minor != 5'd4) begin
                sh_bad++;
            end
            if (t_in) sh_bad++;
            tick();
        end
        chk("long_width", 32'(n), 36);
        chk("long_sh_count", 32'(sh_cnt), 18);
        chk("long_sh_bad", 32'(sh_bad), 0);
        chk("long_ack", 32'(ack), 1);
        chk("long_sh_after", 32'(second_half), 0);
        req = 1'b0;
        tick();

        // Reset asserted on the 10th XFER cycle of a short write
        c0 = cyc;
        req = 1'b1; req_write = 1'b1; req_long = 1'b0; req_addr = 10'h0A7;
        tick();
        while (!t_in && (cyc - c0) < 700) tick();
        chk("rst_rise_minor", 32'(minor), 7);
        chk("rst_tank", 32'(tank_num), 5);
        repeat (9) tick();
        chk("rst_xfer10_t_in", 32'(t_in), 1);
        rst = 1'b1;
        req = 1'b0;
        tick();
        r0 = cyc;
        chk_all_zero("midrst");
        rst = 1'b0;
        acks = 0;
        repeat (40) begin
            tick();
            if (ack || busy || t_in || t_out) acks++;
        end
        chk("rst_no_ack", 32'(acks), 0);

        // Fresh read after reset, then held req for a back-to-back second access
        req = 1'b1; req_write = 1'b0; req_long = 1'b0; req_addr = 10'h0A6;
        tick();
        while (!t_out && (cyc - r0) < 800) tick();
        chk("post_rst_rise", 32'(cyc - r0), 108);
        n = 0;
        while (t_out && n < 100) begin
            n++;
            tick();
        end
        chk("post_rst_width", 32'(n), 18);
        chk("post_rst_ack", 32'(ack), 1);
        tick();
        chk("b2b_ack1_width", 32'(ack), 0);
        chk("b2b_idle_busy", 32'(busy), 0);
        tick();
        chk("b2b_recapture", 32'(busy), 1);
        while (!t_out && (cyc - r0) < 1500) tick();
        chk("b2b_rise", 32'(cyc - r0), 684);
        n = 0;
        while (t_out && n < 100) begin
            n++;
            tick();
        end
        chk("b2b_width", 32'(n), 18);
        chk("b2b_ack2", 32'(ack), 1);
        chk("b2b_ack2_cycle", 32'(cyc - r0), 702);
        req = 1'b0;
        tick();
        chk("b2b_ack2_width", 32'(ack), 0);
        chk("b2b_final_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
